// File: rtl/imem_prog.sv
// rtl/imem_prog.sv - writable instruction memory with post-reset clear, fetch handshake and fault reporting
module imem_prog #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 64,
  parameter int          ADDR_W      = 32,
  parameter bit          RESET_CLEAR = 1'b1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   instruction,
  output logic [1:0]        fetch_err,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [XLEN-1:0]   prog_data,
  output logic              prog_err,
  output logic              busy
);

  localparam int OFF   = $clog2(XLEN / 8);
  localparam int IDX_W = ADDR_W - OFF;
  localparam int DW    = $clog2(DEPTH);

  localparam logic [XLEN-1:0]  NOP_X   = XLEN'(NOP_WORD);
  localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
  localparam logic [DW-1:0]    LAST_I  = DW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RST_STATE = RESET_CLEAR ? S_CLEAR : S_READY;

  // {out_of_range, misaligned}; range uses the full word index so high addresses never alias
  function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] a);
    addr_fault = {a[ADDR_W-1:OFF] >= DEPTH_I, |a[OFF-1:0]};
  endfunction

  state_t          state, state_nx;
  logic [DW-1:0]   clear_idx, clear_idx_nx;
  logic [XLEN-1:0] mem [0:DEPTH-1];

  logic       prog_fire, fetch_fire;
  logic [1:0] prog_fault, fetch_fault;

  assign prog_fault  = addr_fault(prog_addr);
  assign fetch_fault = addr_fault(fetch_addr);
  assign prog_fire   = prog_valid && prog_ready;
  assign fetch_fire  = fetch_req && fetch_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_STATE;
      clear_idx <= '0;
    end else begin
      state     <= state_nx;
      clear_idx <= clear_idx_nx;
    end
  end

  // Handshake readies are gated by reset so nothing is offered while it is held
  always_comb begin
    state_nx     = state;
    clear_idx_nx = clear_idx;
    busy         = 1'b0;
    prog_ready   = 1'b0;
    fetch_ready  = 1'b0;
    case (state)
      S_CLEAR: begin
        busy         = 1'b1;
        clear_idx_nx = clear_idx + 1'b1;
        if (clear_idx == LAST_I) state_nx = S_READY;
      end
      S_READY: begin
        prog_ready  = reset;
        fetch_ready = reset && !prog_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (busy && reset) begin
      mem[clear_idx] <= NOP_X;
    end else if (prog_fire && prog_fault == 2'b00) begin
      mem[prog_addr[OFF+DW-1:OFF]] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      instruction <= NOP_X;
      fetch_err   <= 2'b00;
      prog_err    <= 1'b0;
    end else begin
      prog_err    <= prog_fire && (prog_fault != 2'b00);
      fetch_valid <= fetch_fire;
      if (fetch_fire) begin
        if (fetch_fault != 2'b00) begin
          instruction <= NOP_X;
          fetch_err   <= fetch_fault;
        end else begin
          instruction <= mem[fetch_addr[OFF+DW-1:OFF]];
          fetch_err   <= 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// tb/tb_imem_prog.sv - directed bench for imem_prog with a word-level reference model
module tb_imem_prog;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] instruction;
  logic [1:0]  fetch_err;
  logic        prog_valid;
  logic        prog_ready;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_err;
  logic        busy;

  imem_prog #(
    .XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .RESET_CLEAR(1'b1), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .instruction(instruction), .fetch_err(fetch_err),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_err(prog_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory image plus expected registered outputs
  logic [31:0] mm [0:DEPTH-1];
  int          edges;
  logic        exp_fv, exp_perr;
  logic [31:0] exp_instr;
  logic [1:0]  exp_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] idx;
    if (!reset) begin
      edges = 0; exp_fv = 0; exp_perr = 0; exp_instr = NOP; exp_err = 0;
    end else if (edges < DEPTH) begin
      mm[edges] = NOP;
      edges++;
      exp_fv = 0; exp_perr = 0;
    end else begin
      exp_fv = 0; exp_perr = 0;
      if (prog_valid) begin
        idx = prog_addr >> 2;
        if ((prog_addr & 32'd3) == 0 && idx < DEPTH) mm[idx] = prog_data;
        else exp_perr = 1;
      end else if (fetch_req) begin
        idx = fetch_addr >> 2;
        exp_fv = 1;
        exp_err = {idx >= DEPTH, (fetch_addr & 32'd3) != 0};
        exp_instr = (exp_err != 0) ? NOP : mm[idx];
      end
    end
  endtask

  task automatic compare();
    logic rdy;
    if (!reset) begin
      chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
      chk("rst_instruction", instruction, NOP);
      chk("rst_fetch_err", {30'b0, fetch_err}, 32'd0);
      chk("rst_prog_err", {31'b0, prog_err}, 32'd0);
      chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
      chk("rst_prog_ready", {31'b0, prog_ready}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
    end else begin
      rdy = (edges >= DEPTH);
      chk("busy", {31'b0, busy}, {31'b0, !rdy});
      chk("prog_ready", {31'b0, prog_ready}, {31'b0, rdy});
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, rdy && !prog_valid});
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_fv});
      chk("prog_err", {31'b0, prog_err}, {31'b0, exp_perr});
      chk("instruction", instruction, exp_instr);
      chk("fetch_err", {30'b0, fetch_err}, {30'b0, exp_err});
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are compared at the falling edge
  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic fetch_lit(input string name, input logic [31:0] a,
                           input logic [31:0] want_i, input logic [1:0] want_e);
    fetch_req = 1; fetch_addr = a;
    cyc();
    fetch_req = 0;
    chk({name, "_valid"}, {31'b0, fetch_valid}, 32'd1);
    chk({name, "_instr"}, instruction, want_i);
    chk({name, "_err"}, {30'b0, fetch_err}, {30'b0, want_e});
  endtask

  task automatic write_lit(input string name, input logic [31:0] a,
                           input logic [31:0] d, input logic want_perr);
    prog_valid = 1; prog_addr = a; prog_data = d;
    cyc();
    prog_valid = 0;
    chk({name, "_perr"}, {31'b0, prog_err}, {31'b0, want_perr});
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      cyc();
    end
    chk(name, n, 32'd64);
  endtask

  initial begin
    reset = 0; fetch_req = 0; fetch_addr = 0;
    prog_valid = 0; prog_addr = 0; prog_data = 0;
    cyc(); cyc();
    reset = 1;
    count_busy("clear_busy_cycles");

    fetch_lit("clr_0x00", 32'h00, NOP, 2'b00);
    fetch_lit("clr_0x7c", 32'h7C, NOP, 2'b00);
    fetch_lit("clr_0xfc", 32'hFC, NOP, 2'b00);

    write_lit("prog_0x10", 32'h10, 32'h00A5_0533, 1'b0);
    fetch_lit("fetch_0x10", 32'h10, 32'h00A5_0533, 2'b00);

    fetch_lit("mis_0x12", 32'h12, NOP, 2'b01);
    fetch_lit("oor_0x100", 32'h100, NOP, 2'b10);
    fetch_lit("both_0x102", 32'h102, NOP, 2'b11);
    write_lit("bad_wr_0x101", 32'h101, 32'h1234_5678, 1'b1);
    cyc();
    chk("perr_pulse_low", {31'b0, prog_err}, 32'd0);
    fetch_lit("refetch_0x100", 32'h100, NOP, 2'b10);
    fetch_lit("no_wrap_0x00", 32'h00, NOP, 2'b00);
    fetch_lit("keep_0x10", 32'h10, 32'h00A5_0533, 2'b00);

    fetch_req = 1; fetch_addr = 32'h10;
    prog_valid = 1; prog_addr = 32'h10; prog_data = 32'hDEAD_BEEF;
    #1;
    chk("stall_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    cyc();
    prog_valid = 0;
    chk("stall_no_valid", {31'b0, fetch_valid}, 32'd0);
    #1;
    chk("stall_release_ready", {31'b0, fetch_ready}, 32'd1);
    cyc();
    fetch_req = 0;
    chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
    chk("stall_instr", instruction, 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) write_lit("b2b_wr", 32'(4 * i), 32'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1; fetch_addr = 32'(4 * i);
      cyc();
      chk("b2b_valid", {31'b0, fetch_valid}, 32'd1);
      chk("b2b_instr", instruction, 32'(i + 1));
    end
    fetch_req = 0;
    cyc();
    chk("b2b_valid_drop", {31'b0, fetch_valid}, 32'd0);

    reset = 0;
    cyc();
    reset = 1;
    for (int i = 0; i < 20; i++) cyc();
    reset = 0;
    #1;
    chk("midclr_busy", {31'b0, busy}, 32'd1);
    chk("midclr_instr", instruction, NOP);
    chk("midclr_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("midclr_prog_ready", {31'b0, prog_ready}, 32'd0);
    cyc();
    reset = 1;
    fetch_req = 1; fetch_addr = 32'h10;
    count_busy("reclear_busy_cycles");
    cyc();
    fetch_req = 0;
    chk("held_fetch_valid", {31'b0, fetch_valid}, 32'd1);
    chk("held_fetch_instr", instruction, NOP);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
